run_detect_scheduler: RTL and testbench
=======================================

Name: run_detect_scheduler

Overview:
Shares one serial three-in-a-row bit-run detector (detects 000 or 111, overlapping) between two word requesters. Round-robin arbitrates the requesters and accepts one DATA_W-bit word per transaction. Serializes the word MSB-first into the detector and counts detections. Returns the count and requester id on a valid/ready result channel.

Parameters:
DATA_W, 8, word width in bits (>=3)
CNT_W, 4, result count width; must satisfy 2^CNT_W > DATA_W-2

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 word valid
req0_data  input  DATA_W  requester 0 word
req0_ready  output  1  requester 0 accept
req1_valid  input  1  requester 1 word valid
req1_data  input  DATA_W  requester 1 word
req1_ready  output  1  requester 1 accept
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_id  output  1  requester id of result
res_count  output  CNT_W  number of detections in word
busy  output  1  state != IDLE
det_pulse  output  1  per-bit detector output, gated by SHIFT

Behaviour:
- Clock is clk; reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE; res_valid=0, res_id=0, res_count=0, busy=0, det_pulse=0.
  - last_grant=1, so req0 wins the first tie.
  - Detector state=START.
- FSM states: IDLE, SHIFT, REPORT. No other encodings reachable; any illegal encoding goes to IDLE.
- IDLE arbitration:
  - grant = the only valid requester; if both are valid, the one != last_grant.
  - reqX_ready = (state==IDLE) && grant==X. This path is combinational from valid; only one ready is high at a time.
- IDLE accept: on valid&&ready, load the shift register with the data, latch id, set last_grant=id, clear the count, sync-clear the detector to START, set bit_idx=0, go to SHIFT.
- SHIFT:
  - Each cycle, the shift register MSB drives the detector input with enable=1.
  - The detector's Mealy output (combinational, same cycle) adds to the count at the edge; shift left; bit_idx++.
  - At the edge where bit_idx==DATA_W-1, the final bit is counted and the FSM goes to REPORT.
- Latency: with the accept edge as E0, res_valid is high after edge E_DATA_W, i.e. DATA_W edges later. Throughput is one word per DATA_W+2 cycles minimum.
- Detector (Mealy, history cleared per word):
  - States START, ZERO1, ONE1, ZERO2, ONE2.
  - Input 0 goes to ZERO1 from START/ONE1/ONE2, and to ZERO2 from ZERO1/ZERO2.
  - Input 1 is symmetric.
  - out=1 iff (ZERO2 && in==0) || (ONE2 && in==1).
  - When enable=0 the detector holds its state.
- Count semantics: number of positions i in 2..DATA_W-1 (MSB = position 0) where bits i-2, i-1, i are equal. Max is DATA_W-2, with no saturation needed.
- REPORT:
  - res_valid=1; res_id and res_count are held stable until res_ready.
  - On the handshake, go to IDLE; res_valid drops the next cycle.
  - No new word is accepted during SHIFT or REPORT; both readies are 0.
- det_pulse = detector out && state==SHIFT.
- Reset mid-operation: immediate return to reset values; the in-flight word and count are discarded; no partial result is emitted.
- Simultaneous res handshake and new request valid: the new word is accepted no earlier than the following IDLE cycle.

Decomposition:
- Shared package:
  - Scheduler state encodings IDLE/SHIFT/REPORT.
  - Detector state encodings START/ZERO1/ONE1/ZERO2/ONE2.
  - Requester id constants REQ0=0, REQ1=1.
- Sub-module bit_run_detector (clk, rst, clr, en, din, dout): the Mealy detector with sync clear and enable. The scheduler instantiates it once.

Test Plan:
1. req0_valid with 0x00 only -> req0_ready=1 same cycle; res_valid 8 edges after accept; res_id=0, res_count=6; det_pulse high on the last 6 shift cycles.
2. req1 0xAA -> res_id=1, res_count=0. Then req1 0xE3 -> res_count=2. Then 0xF0 -> res_count=4.
3. After reset, both valid continuously (req0=0xF0, req1=0xFF) -> grant order 0,1,0,1; results (0,4), (1,6), (0,4), (1,6).
4. History isolation: word 0x03 -> count 4, then word 0xFF -> count 6. Carry-over from the previous word's trailing 11 must not add a detection.
5. Backpressure: hold res_ready=0 for 5 cycles in REPORT -> res_valid, res_id and res_count stable; both readies 0; busy=1. Release -> one handshake, then IDLE.
6. Assert rst after 3 shift cycles -> res_valid=0, busy=0, last_grant=1 immediately. Next 0x00 from req1 -> res_count=6, no stale count.

Source files
------------

// File: rtl/run_detect_scheduler_pkg.sv
// Shared encodings for the run-detect scheduler: scheduler FSM states,
// bit-run detector states and requester ids.
package run_detect_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } sched_state_t;

    typedef enum logic [2:0] {
        START = 3'd0,
        ZERO1 = 3'd1,
        ONE1  = 3'd2,
        ZERO2 = 3'd3,
        ONE2  = 3'd4
    } det_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/run_detect_scheduler_bit_run_detector.sv
// Serial Mealy detector for three equal bits in a row (000 or 111, overlapping).
// Synchronous clear drops the history between words; enable low holds state.
module bit_run_detector
    import run_detect_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    det_state_t state;
    det_state_t next_state;

    // Two-deep run history per polarity; a third equal bit fires the output.
    always_comb begin
        next_state = START;
        case (state)
            START, ONE1, ONE2:   next_state = din ? ((state == START) ? ONE1 : ONE2) : ZERO1;
            ZERO1, ZERO2:        next_state = din ? ONE1 : ZERO2;
            default:             next_state = START;
        endcase
    end

    assign dout = ((state == ZERO2) && !din) || ((state == ONE2) && din);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
        end else if (clr) begin
            state <= START;
        end else if (en) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/run_detect_scheduler.sv
// Round-robin shares one serial bit-run detector between two word requesters
// and returns the per-word detection count on a valid/ready result channel.
module run_detect_scheduler
    import run_detect_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy,
    output logic              det_pulse
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    sched_state_t      state;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_grant;
    logic              grant;
    logic              any_valid;
    logic              accept;
    logic              det_out;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = REQ0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = REQ1;
        end
    end

    assign any_valid  = req0_valid || req1_valid;
    assign accept     = (state == IDLE) && any_valid;
    assign req0_ready = accept && (grant == REQ0);
    assign req1_ready = accept && (grant == REQ1);
    assign det_pulse  = det_out && (state == SHIFT);

    bit_run_detector u_detector (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state == SHIFT),
        .din  (shift_reg[DATA_W-1]),
        .dout (det_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            last_grant <= REQ1;
            res_id     <= REQ0;
            res_count  <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= (grant == REQ1) ? req1_data : req0_data;
                        res_id     <= grant;
                        last_grant <= grant;
                        res_count  <= '0;
                        bit_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_count <= res_count + CNT_W'(det_out);
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    bit_idx   <= bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Bench for run_detect_scheduler: directed words plus random traffic checked
// against a word-level model of arbitration and run counting.
module tb_run_detect_scheduler;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_id;
    logic [CNT_W-1:0]  res_count;
    logic              busy;
    logic              det_pulse;

    int total = 0;
    int bad   = 0;
    logic model_last = 1'b1;

    run_detect_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_count  (res_count),
        .busy       (busy),
        .det_pulse  (det_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic bitAt(input logic [DATA_W-1:0] w, input int p);
        return w[DATA_W-1-p];
    endfunction

    function automatic logic runAt(input logic [DATA_W-1:0] w, input int p);
        if (p < 2) return 1'b0;
        return (bitAt(w, p) == bitAt(w, p-1)) && (bitAt(w, p-1) == bitAt(w, p-2));
    endfunction

    function automatic int countRuns(input logic [DATA_W-1:0] w);
        int n = 0;
        for (int p = 2; p < DATA_W; p++) n += int'(runAt(w, p));
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // One full transaction from IDLE: arbitration, shifting, optional result stall, handshake.
    task automatic applyStimulus(input logic v0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [DATA_W-1:0] d1, input int hold);
        logic g;
        logic [DATA_W-1:0] w;
        g = (v0 && v1) ? ~model_last : (v0 ? 1'b0 : 1'b1);
        w = g ? d1 : d0;
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        res_ready  = 1'b0;
        #1;
        checkOutput("ready0", 32'(req0_ready), 32'(g == 1'b0));
        checkOutput("ready1", 32'(req1_ready), 32'(g == 1'b1));
        for (int p = 0; p < DATA_W; p++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("det_pulse[%0d]", p), 32'(det_pulse), 32'(runAt(w, p)));
            if (p == DATA_W - 1) begin
                checkOutput("res_valid_early", 32'(res_valid), 32'd0);
                checkOutput("busy_shift", 32'(busy), 32'd1);
                checkOutput("readies_shift", 32'({req0_ready, req1_ready}), 32'd0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_valid", 32'(res_valid), 32'd1);
            checkOutput("hold_id", 32'(res_id), 32'(g));
            checkOutput("hold_count", 32'(res_count), 32'(countRuns(w)));
            checkOutput("hold_readies", 32'({req0_ready, req1_ready}), 32'd0);
            checkOutput("hold_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        #1;
        checkOutput("res_valid", 32'(res_valid), 32'd1);
        checkOutput("res_id", 32'(res_id), 32'(g));
        checkOutput("res_count", 32'(res_count), 32'(countRuns(w)));
        checkOutput("readies_report", 32'({req0_ready, req1_ready}), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checkOutput("res_valid_drop", 32'(res_valid), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        model_last = g;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(res_count), 32'd0);
        checkOutput("rst_id", 32'(res_id), 32'd0);
        checkOutput("rst_det", 32'(det_pulse), 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput("rst_tie_ready0", 32'(req0_ready), 32'd1);
        checkOutput("rst_tie_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic v0, v1;
        applyReset();

        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hAA, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hE3, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hF0, 0);

        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hF0, 1'b1, 8'hFF, 0);

        applyStimulus(1'b1, 8'h03, 1'b0, 8'h00, 0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 0);

        applyStimulus(1'b1, 8'h5C, 1'b1, 8'h38, 5);

        // Abort a word three shift cycles in; nothing of it may leak out.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hFF;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        applyReset();
        checkOutput("post_rst_valid", 32'(res_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(v0, 8'($urandom), v1, 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
